// File: rtl/fifo_ctrl_param.sv
// fifo_ctrl_param: single-clock FIFO with write/read control, storage,
// occupancy count, almost-full/almost-empty thresholds, sticky overflow and
// underflow flags, and a registered read-data path.
module fifo_ctrl_param #(
   parameter int MEM_SIZE  = 4,
   parameter int WORD_SIZE = 6,
   parameter int PTR_L     = 2,
   parameter int AF_THRESH = 3,
   parameter int AE_THRESH = 1
) (
   input  logic                 clk,
   input  logic                 reset_L,
   input  logic                 fifo_wr,
   input  logic                 fifo_rd,
   input  logic [WORD_SIZE-1:0] data_in,
   input  logic                 err_clr,
   output logic [WORD_SIZE-1:0] data_out,
   output logic                 valid_out,
   output logic                 push,
   output logic                 pop,
   output logic [PTR_L-1:0]     wr_ptr,
   output logic [PTR_L-1:0]     rd_ptr,
   output logic [PTR_L:0]       count,
   output logic                 fifo_full,
   output logic                 fifo_empty,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic                 overflow_err,
   output logic                 underflow_err
);

   // Pointers wrap at MEM_SIZE-1, which need not be 2**PTR_L-1.
   localparam logic [PTR_L-1:0] LAST_PTR = PTR_L'(MEM_SIZE - 1);
   localparam logic [PTR_L-1:0] PTR_ONE  = PTR_L'(1);
   localparam logic [PTR_L:0]   FULL_CNT = (PTR_L + 1)'(MEM_SIZE);
   localparam logic [PTR_L:0]   AF_CNT   = (PTR_L + 1)'(AF_THRESH);
   localparam logic [PTR_L:0]   AE_CNT   = (PTR_L + 1)'(AE_THRESH);
   localparam logic [PTR_L:0]   CNT_ONE  = (PTR_L + 1)'(1);

   logic [WORD_SIZE-1:0] mem_q [MEM_SIZE];

   logic [PTR_L-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_L-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_L:0]       count_q, count_d;
   logic [WORD_SIZE-1:0] data_out_q, data_out_d;
   logic                 valid_out_q, valid_out_d;
   logic                 overflow_q, overflow_d;
   logic                 underflow_q, underflow_d;

   // Status flags decoded from the registered occupancy count.
   always_comb begin
      fifo_full    = (count_q == FULL_CNT);
      fifo_empty   = (count_q == '0);
      almost_full  = (count_q >= AF_CNT);
      almost_empty = (count_q <= AE_CNT);
   end

   // Request acceptance; a read frees a slot so a full FIFO can still accept
   // a simultaneous write. Both are suppressed while reset is asserted.
   always_comb begin
      pop  = reset_L & fifo_rd & ~fifo_empty;
      push = reset_L & fifo_wr & (~fifo_full | pop);
   end

   // Next-state computation for pointers, count, read data and error flags.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned; that is what keeps this block from inferring latches.
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      data_out_d  = data_out_q;
      valid_out_d = 1'b0;

      if (push) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d    = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_ONE;
         data_out_d  = mem_q[rd_ptr_q];
         valid_out_d = 1'b1;
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      // A set on the same edge as a clear wins.
      overflow_d  = (fifo_wr & ~push) | (overflow_q  & ~err_clr);
      underflow_d = (fifo_rd & ~pop)  | (underflow_q & ~err_clr);
   end

   // Control and status state with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_L) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!reset_L) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         data_out_q  <= '0;
         valid_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage array write port.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; stored words are only ever observed
      // after being written, and leaving it unreset lets it map to RAM.
      if (push) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   // Drive outputs from the registered state.
   always_comb begin
      wr_ptr        = wr_ptr_q;
      rd_ptr        = rd_ptr_q;
      count         = count_q;
      data_out      = data_out_q;
      valid_out     = valid_out_q;
      overflow_err  = overflow_q;
      underflow_err = underflow_q;
   end

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Directed testbench for fifo_ctrl_param: default 4-entry instance plus a
// 5-entry instance for non-power-of-two pointer wrap.
module tb_fifo_ctrl_param;

   logic       clk;
   logic       reset_L;

   // Default instance (MEM_SIZE=4)
   logic       fifo_wr, fifo_rd, err_clr;
   logic [5:0] data_in, data_out;
   logic       valid_out, push, pop;
   logic [1:0] wr_ptr, rd_ptr;
   logic [2:0] count;
   logic       fifo_full, fifo_empty, almost_full, almost_empty;
   logic       overflow_err, underflow_err;

   // Second instance (MEM_SIZE=5, PTR_L=3)
   logic       wr5, rd5, clr5;
   logic [5:0] din5, dout5;
   logic       valid5, push5, pop5;
   logic [2:0] wrp5, rdp5;
   logic [3:0] cnt5;
   logic       full5, empty5, af5, ae5, ovf5, udf5;

   int total = 0;
   int bad   = 0;

   fifo_ctrl_param dut (
      .clk(clk), .reset_L(reset_L), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
      .data_in(data_in), .err_clr(err_clr), .data_out(data_out),
      .valid_out(valid_out), .push(push), .pop(pop), .wr_ptr(wr_ptr),
      .rd_ptr(rd_ptr), .count(count), .fifo_full(fifo_full),
      .fifo_empty(fifo_empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .overflow_err(overflow_err),
      .underflow_err(underflow_err)
   );

   fifo_ctrl_param #(.MEM_SIZE(5), .WORD_SIZE(6), .PTR_L(3),
                     .AF_THRESH(4), .AE_THRESH(1)) dut5 (
      .clk(clk), .reset_L(reset_L), .fifo_wr(wr5), .fifo_rd(rd5),
      .data_in(din5), .err_clr(clr5), .data_out(dout5),
      .valid_out(valid5), .push(push5), .pop(pop5), .wr_ptr(wrp5),
      .rd_ptr(rdp5), .count(cnt5), .fifo_full(full5),
      .fifo_empty(empty5), .almost_full(af5),
      .almost_empty(ae5), .overflow_err(ovf5),
      .underflow_err(udf5)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic drive(input logic wr, input logic rd, input logic [5:0] din,
                        input logic clr);
      fifo_wr = wr;
      fifo_rd = rd;
      data_in = din;
      err_clr = clr;
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_L = 1'b0;
      drive(1'b1, 1'b1, 6'h3F, 1'b0);
      wr5 = 1'b0; rd5 = 1'b0; din5 = '0; clr5 = 1'b0;
      #12;
      total++; if (push !== 1'b0 || pop !== 1'b0) begin bad++; $display("FAIL reset_accept got push=%b pop=%b exp 0 0", push, pop); end
      total++; if (count !== 3'd0 || wr_ptr !== 2'd0 || rd_ptr !== 2'd0) begin bad++; $display("FAIL reset_state got cnt=%0d wp=%0d rp=%0d exp 0 0 0", count, wr_ptr, rd_ptr); end
      total++; if ({fifo_empty, almost_empty, fifo_full, almost_full} !== 4'b1100) begin bad++; $display("FAIL reset_flags got e/ae/f/af=%b exp 1100", {fifo_empty, almost_empty, fifo_full, almost_full}); end
      total++; if ({valid_out, overflow_err, underflow_err} !== 3'b000 || data_out !== 6'h00) begin bad++; $display("FAIL reset_out got v/o/u=%b dout=%h exp 000 00", {valid_out, overflow_err, underflow_err}, data_out); end
      drive(1'b0, 1'b0, 6'h00, 1'b0);
      @(negedge clk);
      reset_L = 1'b1;
      tick();
      total++; if (count !== 3'd0 || fifo_empty !== 1'b1) begin bad++; $display("FAIL reset_release got cnt=%0d empty=%b exp 0 1", count, fifo_empty); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 6'(i + 1), 1'b0);
         #1;
         total++; if (push !== 1'b1) begin bad++; $display("FAIL fill_push[%0d] got=%b exp=1", i, push); end
         tick();
         total++; if (count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
         total++; if (almost_full !== (i + 1 >= 3) || almost_empty !== (i + 1 <= 1)) begin bad++; $display("FAIL fill_almost[%0d] got af=%b ae=%b exp af=%b ae=%b", i, almost_full, almost_empty, (i + 1 >= 3), (i + 1 <= 1)); end
         total++; if (fifo_full !== (i == 3) || fifo_empty !== 1'b0) begin bad++; $display("FAIL fill_full[%0d] got full=%b empty=%b exp full=%b empty=0", i, fifo_full, fifo_empty, (i == 3)); end
         total++; if (wr_ptr !== 2'((i + 1) % 4)) begin bad++; $display("FAIL fill_wrptr[%0d] got=%0d exp=%0d", i, wr_ptr, (i + 1) % 4); end
      end
   endtask

   task automatic test_overflow();
      drive(1'b1, 1'b0, 6'h3F, 1'b0);
      #1;
      total++; if (push !== 1'b0) begin bad++; $display("FAIL ovf_push got=%b exp=0", push); end
      tick();
      total++; if (count !== 3'd4 || wr_ptr !== 2'd0 || overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_state got cnt=%0d wp=%0d ovf=%b exp 4 0 1", count, wr_ptr, overflow_err); end
      drive(1'b0, 1'b0, 6'h00, 1'b0);
      tick();
      total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow_err); end
      drive(1'b0, 1'b0, 6'h00, 1'b1);
      tick();
      total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow_err); end
      // Rejected write and clear on the same edge: set wins.
      drive(1'b1, 1'b0, 6'h3E, 1'b1);
      tick();
      total++; if (overflow_err !== 1'b1 || count !== 3'd4) begin bad++; $display("FAIL ovf_setwins got ovf=%b cnt=%0d exp 1 4", overflow_err, count); end
      drive(1'b0, 1'b0, 6'h00, 1'b1);
      tick();
      total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL ovf_clear2 got=%b exp=0", overflow_err); end
      drive(1'b0, 1'b0, 6'h00, 1'b0);
   endtask

   task automatic test_full_rw();
      logic [5:0] exp_q [4] = '{6'h02, 6'h03, 6'h04, 6'h2A};
      drive(1'b1, 1'b1, 6'h2A, 1'b0);
      #1;
      total++; if (push !== 1'b1 || pop !== 1'b1) begin bad++; $display("FAIL fullrw_accept got push=%b pop=%b exp 1 1", push, pop); end
      tick();
      total++; if (count !== 3'd4 || wr_ptr !== 2'd1 || rd_ptr !== 2'd1) begin bad++; $display("FAIL fullrw_state got cnt=%0d wp=%0d rp=%0d exp 4 1 1", count, wr_ptr, rd_ptr); end
      total++; if (valid_out !== 1'b1 || data_out !== 6'h01) begin bad++; $display("FAIL fullrw_data got v=%b d=%h exp 1 01", valid_out, data_out); end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 6'h00, 1'b0);
         tick();
         total++; if (valid_out !== 1'b1 || data_out !== exp_q[i]) begin bad++; $display("FAIL drain_data[%0d] got v=%b d=%h exp 1 %h", i, valid_out, data_out, exp_q[i]); end
      end
      total++; if (count !== 3'd0 || fifo_empty !== 1'b1) begin bad++; $display("FAIL drain_empty got cnt=%0d empty=%b exp 0 1", count, fifo_empty); end
      drive(1'b0, 1'b0, 6'h00, 1'b0);
      tick();
      total++; if (valid_out !== 1'b0 || data_out !== 6'h2A || underflow_err !== 1'b0) begin bad++; $display("FAIL idle_hold got v=%b d=%h udf=%b exp 0 2a 0", valid_out, data_out, underflow_err); end
   endtask

   task automatic test_underflow();
      drive(1'b1, 1'b1, 6'h15, 1'b0);
      #1;
      total++; if (pop !== 1'b0 || push !== 1'b1) begin bad++; $display("FAIL udf_accept got push=%b pop=%b exp 1 0", push, pop); end
      tick();
      total++; if (underflow_err !== 1'b1 || count !== 3'd1 || valid_out !== 1'b0) begin bad++; $display("FAIL udf_state got udf=%b cnt=%0d v=%b exp 1 1 0", underflow_err, count, valid_out); end
      drive(1'b0, 1'b1, 6'h00, 1'b0);
      tick();
      total++; if (valid_out !== 1'b1 || data_out !== 6'h15 || count !== 3'd0) begin bad++; $display("FAIL udf_read got v=%b d=%h cnt=%0d exp 1 15 0", valid_out, data_out, count); end
      total++; if (wr_ptr !== 2'd2 || rd_ptr !== 2'd2) begin bad++; $display("FAIL udf_ptrs got wp=%0d rp=%0d exp 2 2", wr_ptr, rd_ptr); end
      drive(1'b0, 1'b0, 6'h00, 1'b1);
      tick();
      total++; if (underflow_err !== 1'b0) begin bad++; $display("FAIL udf_clear got=%b exp=0", underflow_err); end
      drive(1'b0, 1'b0, 6'h00, 1'b0);
   endtask

   task automatic test_wrap5();
      logic [5:0] val;
      for (int k = 0; k < 12; k++) begin
         val = 6'((k * 5 + 3) & 63);
         total++; if (wrp5 !== 3'(k % 5) || rdp5 !== 3'(k % 5)) begin bad++; $display("FAIL wrap5_ptrs[%0d] got wp=%0d rp=%0d exp %0d", k, wrp5, rdp5, k % 5); end
         wr5 = 1'b1; rd5 = 1'b0; din5 = val;
         tick();
         wr5 = 1'b0; rd5 = 1'b1;
         tick();
         total++; if (valid5 !== 1'b1 || dout5 !== val) begin bad++; $display("FAIL wrap5_data[%0d] got v=%b d=%h exp 1 %h", k, valid5, dout5, val); end
      end
      rd5 = 1'b0;
      total++; if (wrp5 !== 3'd2 || rdp5 !== 3'd2 || cnt5 !== 4'd0) begin bad++; $display("FAIL wrap5_end got wp=%0d rp=%0d cnt=%0d exp 2 2 0", wrp5, rdp5, cnt5); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 6'(6'h30 + i), 1'b0);
         tick();
      end
      drive(1'b0, 1'b1, 6'h00, 1'b0);
      tick();
      drive(1'b1, 1'b0, 6'h07, 1'b0);
      total++; if (count !== 3'd2 || valid_out !== 1'b1) begin bad++; $display("FAIL arst_pre got cnt=%0d v=%b exp 2 1", count, valid_out); end
      tick();
      total++; if (count !== 3'd3) begin bad++; $display("FAIL arst_pre3 got cnt=%0d exp 3", count); end
      @(negedge clk);
      #2;
      reset_L = 1'b0;
      #1;
      total++; if (count !== 3'd0 || wr_ptr !== 2'd0 || rd_ptr !== 2'd0 || fifo_empty !== 1'b1) begin bad++; $display("FAIL arst_state got cnt=%0d wp=%0d rp=%0d empty=%b exp 0 0 0 1", count, wr_ptr, rd_ptr, fifo_empty); end
      total++; if (push !== 1'b0 || data_out !== 6'h00 || valid_out !== 1'b0) begin bad++; $display("FAIL arst_out got push=%b d=%h v=%b exp 0 00 0", push, data_out, valid_out); end
      @(negedge clk);
      reset_L = 1'b1;
      drive(1'b1, 1'b0, 6'h11, 1'b0);
      tick();
      drive(1'b0, 1'b1, 6'h00, 1'b0);
      tick();
      total++; if (data_out !== 6'h11 || valid_out !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL arst_after got d=%h v=%b cnt=%0d exp 11 1 0", data_out, valid_out, count); end
      drive(1'b0, 1'b0, 6'h00, 1'b0);
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_full_rw();
      test_underflow();
      test_wrap5();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_ctrl_param.md
Name: fifo_ctrl_param

Overview:
Parametrised single-clock FIFO that combines write control, read control, storage and status in one block. It succeeds the stand-alone write-pointer logic. It adds a read side, an occupancy counter, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a registered read-data path. It is instantiated once per channel inside the interconnect device, between the input demux and the output arbiter.

Parameters:
MEM_SIZE, 4, number of entries; any value >= 2, power of two not required
WORD_SIZE, 6, data width in bits
PTR_L, 2, pointer width; must satisfy 2**PTR_L >= MEM_SIZE
AF_THRESH, 3, almost_full asserts when count >= AF_THRESH (1..MEM_SIZE)
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH (0..MEM_SIZE-1)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_L  in  1  asynchronous, active-low reset
fifo_wr  in  1  write request
fifo_rd  in  1  read request
data_in  in  WORD_SIZE  write data, sampled on clock edges where push=1
err_clr  in  1  synchronous clear of the sticky error flags
data_out  out  WORD_SIZE  registered read data
valid_out  out  1  data_out holds a freshly popped word this cycle
push  out  1  write accepted this cycle (combinational)
pop  out  1  read accepted this cycle (combinational)
wr_ptr  out  PTR_L  write pointer
rd_ptr  out  PTR_L  read pointer
count  out  PTR_L+1  occupancy, 0..MEM_SIZE
fifo_full  out  1  count == MEM_SIZE
fifo_empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
overflow_err  out  1  sticky: a write was rejected
underflow_err  out  1  sticky: a read was rejected

Behaviour:
- Reset (reset_L=0, asynchronous):
  - wr_ptr, rd_ptr, count, data_out, valid_out, overflow_err and underflow_err go to 0 immediately.
  - push and pop are forced to 0 while reset_L is low.
  - Resulting flags: fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0.
  - Memory array is not reset; its contents are don't-care.
  - Reset mid-operation discards all stored words; no partial update occurs on the edge where reset releases.
- Acceptance (combinational):
  - pop = fifo_rd & !fifo_empty.
  - push = fifo_wr & (!fifo_full | pop).
  - When full with both requests, both are accepted and count is unchanged.
  - When empty with both requests, only the write is accepted. There is no fall-through; the word becomes readable on the next cycle.
- Pointers:
  - On push: mem[wr_ptr] <= data_in, and wr_ptr increments.
  - On pop: rd_ptr increments.
  - Each pointer wraps from MEM_SIZE-1 to 0, independent of PTR_L.
- count:
  - +1 on push only; -1 on pop only; unchanged on both or neither.
  - Never exceeds MEM_SIZE and never goes below 0.
- Status flags: fifo_full, fifo_empty, almost_full and almost_empty are decoded combinationally from the count register. They change the cycle after the causing edge.
- Read data:
  - On a pop edge: data_out <= mem[rd_ptr] and valid_out <= 1. Latency is one clock from pop.
  - Otherwise valid_out <= 0 and data_out holds its last value.
- Errors:
  - overflow_err sets on an edge where fifo_wr=1 and push=0.
  - underflow_err sets on an edge where fifo_rd=1 and pop=0.
  - Both flags are sticky until err_clr=1 at a clock edge.
  - If set and clear occur on the same edge, set wins.
- Rejected requests change no pointer, count or memory content.

Test Plan:
- Reset, then 4 writes (0x01..0x04) with MEM_SIZE=4 -> count 1,2,3,4; almost_full rises when count=3; fifo_full=1 after the 4th write; wr_ptr wraps to 0.
- 5th write while full, no read -> push=0, count stays 4, overflow_err=1 and stays 1; err_clr pulse -> overflow_err=0 next cycle.
- Full FIFO, fifo_wr=fifo_rd=1 with data_in=0x2A -> push=pop=1, count stays 4; data_out=0x01 with valid_out=1 one cycle later; 0x2A is read back 4 pops later.
- Empty FIFO, fifo_wr=fifo_rd=1 with data 0x15 -> pop=0, underflow_err=1, count=1; next-cycle read yields 0x15 with valid_out=1.
- MEM_SIZE=5, PTR_L=3: 12 write/read pairs -> pointers follow 0,1,2,3,4,0,...; the sequence read out equals the sequence written.
- Assert reset_L low asynchronously with count=3 -> all outputs reach reset values before the next clk edge; fifo_empty=1.
